country_sensor: RTL and testbench
=================================

# country_sensor

Vehicle-detector conditioning stage that sits directly upstream of the traffic signal controller. It produces the controller's car-present input `x` from a raw, asynchronous, bouncy country-road loop detector. The stage synchronises, debounces and gap-holds the detector signal, and counts vehicles. It also places a fail-safe permanent call when the detector is stuck active.

## Interface
- `DEBOUNCE`, default 4: number of consecutive synchronised samples that must disagree with the debounced level before that level changes (≥1).
- `HOLD`, default 8: number of cycles `x` stays asserted after the debounced detector releases (gap tolerance, ≥1).
- `STUCK`, default 255: number of cycles of continuous presence after which a fault is declared (≥2).
- `CNT_W`, default 8: width of the vehicle counter.
- `clock`  in  1  system clock; all state changes on its rising edge.
- `clear`  in  1  reset, asynchronous and active-high; forces every register to its reset value immediately.
- `det_raw`  in  1  raw loop-detector output, asynchronous to `clock`, 1 = metal detected.
- `count_clr`  in  1  synchronous clear of `car_count`.
- `x`  out  1  car-present request to the signal controller; registered, TRUE=1.
- `car_count`  out  CNT_W  number of vehicles detected; saturating.
- `fault`  out  1  stuck-detector flag; registered.

## Operation
- Reset values: `x`=0, `car_count`=0, `fault`=0, state IDLE, synchroniser flops=0, debounced level=0, all timers=0.
- Synchroniser: two flops in series, `det_raw` → `s1` → `s2`. `det_s` is `s2`.
- Debouncer: register `det_db` and counter `db_cnt`.
  - In any cycle where `det_s` equals `det_db`: `db_cnt` is set to 0.
  - In any cycle where they differ: if `db_cnt` equals DEBOUNCE-1, then `det_db` takes the value of `det_s` and `db_cnt` is set to 0. Otherwise `db_cnt` increments.
- FSM with states IDLE, PRESENT, HOLD, FAULT. Outputs are decoded from the state register: `x`=1 in PRESENT, HOLD and FAULT; `fault`=1 in FAULT only.
  - IDLE: if `det_db`=1, go to PRESENT, increment `car_count`, and set `tmr` to 0.
  - PRESENT: `tmr` increments each cycle.
    - If `det_db`=0, go to HOLD and set `tmr` to 0.
    - Otherwise, if `tmr` equals STUCK-1, go to FAULT.
  - HOLD: `tmr` increments each cycle.
    - If `det_db`=1, go to PRESENT with `tmr`=0 and no count increment (same vehicle).
    - Otherwise, if `tmr` equals HOLD-1, go to IDLE.
  - FAULT: if `det_db`=0, go to IDLE. There is no count and no hold in this transition.
- `car_count` saturates at 2^CNT_W-1.
- `count_clr`:
  - Loads 0.
  - If asserted in the same cycle as an increment, the result is 1 (clear first, then increment).
- `tmr` must be wide enough for max(STUCK, HOLD) without wrap.

## Timing
- Edge numbering: `det_raw` toggles with setup met before edge 1 and stays stable.
- Rise latency: `det_db` changes at edge DEBOUNCE+2; `x` rises at edge DEBOUNCE+3 (7 with defaults). `car_count` updates on the same edge as `x`.
- Fall latency: the FSM enters HOLD at edge DEBOUNCE+3 after release; `x` falls at edge DEBOUNCE+HOLD+3 (15 with defaults).
- Glitch rejection:
  - A `det_raw` pulse narrower than DEBOUNCE cycles never changes `det_db`.
  - A debounced gap shorter than HOLD cycles does not drop `x` and is not counted as a new vehicle.
- Stuck detection: `fault` and FAULT are entered STUCK edges after the edge that entered PRESENT, provided presence is continuous. `x` stays 1 throughout.
- Fault exit: `fault` and `x` fall together DEBOUNCE+3 edges after `det_raw` release.
- Reset: asserting `clear` in any state, including mid-HOLD or mid-FAULT, drops `x` and `fault` without waiting for a clock edge. After `clear` deasserts, the first edge samples `det_raw` normally.

## Test plan
- Reset: assert `clear` with `det_raw`=1 → `x`=0, `fault`=0, `car_count`=0 while `clear` is high.
- Single car, defaults: `det_raw` high for 20 cycles → `x` rises at edge 7 and `car_count`=1. After release, `x` falls exactly 15 edges later.
- Bounce:
  - 3-cycle `det_raw` pulse → `x` never rises, `car_count`=0.
  - 20 high, 5 low, 20 high → `x` stays continuously 1, `car_count`=1.
- Stuck detector: `det_raw` high for 300 cycles with STUCK=255 → `fault`=1 at edge 262 with `x`=1. After release, `fault` and `x` fall together 7 edges later; `car_count`=1.
- Counter with CNT_W=2: five separated cars → `car_count`=3 (saturated). Pulse `count_clr` on the increment edge of a sixth car → `car_count`=1.
- Asynchronous reset mid-operation: pulse `clear` between edges while in HOLD → `x` drops to 0 before the next edge, and the state is IDLE afterwards.

Source files
------------

// File: rtl/country_sensor.sv
// Loop-detector conditioning: synchronise, debounce, gap-hold and count vehicles,
// with a fail-safe permanent call when the detector is stuck active.
module country_sensor #(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned HOLD     = 8,
  parameter int unsigned STUCK    = 255,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             det_raw,
  input  logic             count_clr,
  output logic             x,
  output logic [CNT_W-1:0] car_count,
  output logic             fault,
  output logic [1:0]       state_dbg
);

  localparam int unsigned TMAX  = (STUCK > HOLD) ? STUCK : HOLD;
  localparam int unsigned TMR_W = $clog2(TMAX + 1);
  localparam int unsigned DB_W  = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_HOLD    = 2'd2,
    S_FAULT   = 2'd3
  } state_t;

  state_t            state;
  logic              s1;
  logic              s2;
  logic              det_db;
  logic [DB_W-1:0]   db_cnt;
  logic [TMR_W-1:0]  tmr;
  logic              car_inc;

  // Two-flop synchroniser for the asynchronous detector.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= det_raw;
      s2 <= s1;
    end
  end

  // Level flips only after DEBOUNCE consecutive disagreeing samples.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      det_db <= 1'b0;
      db_cnt <= '0;
    end else if (s2 == det_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_W'(DEBOUNCE - 1)) begin
      det_db <= s2;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= S_IDLE;
      tmr   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (det_db) begin
            state <= S_PRESENT;
            tmr   <= '0;
          end
        end
        S_PRESENT: begin
          tmr <= tmr + 1'b1;
          if (!det_db) begin
            state <= S_HOLD;
            tmr   <= '0;
          end else if (tmr == TMR_W'(STUCK - 1)) begin
            state <= S_FAULT;
          end
        end
        S_HOLD: begin
          tmr <= tmr + 1'b1;
          // Presence returning inside the gap is the same vehicle: no count.
          if (det_db) begin
            state <= S_PRESENT;
            tmr   <= '0;
          end else if (tmr == TMR_W'(HOLD - 1)) begin
            state <= S_IDLE;
          end
        end
        S_FAULT: begin
          if (!det_db) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign car_inc = (state == S_IDLE) && det_db;

  // Clear takes effect before the increment, so clear+increment yields 1.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      car_count <= '0;
    end else if (car_inc) begin
      if (count_clr)                 car_count <= CNT_W'(1);
      else if (car_count != CNT_MAX) car_count <= car_count + 1'b1;
    end else if (count_clr) begin
      car_count <= '0;
    end
  end

  assign x         = (state != S_IDLE);
  assign fault     = (state == S_FAULT);
  assign state_dbg = state;

endmodule

// File: tb/tb_country_sensor.sv
// Bench for country_sensor: directed latency/boundary tests plus random detector
// activity checked every cycle against a behavioural model.
module tb_country_sensor;

  localparam int DEBOUNCE = 4;
  localparam int HOLD     = 8;
  localparam int STUCK    = 255;
  localparam int CNT_W    = 2;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  localparam int M_IDLE    = 0;
  localparam int M_PRESENT = 1;
  localparam int M_HOLD    = 2;
  localparam int M_FAULT   = 3;

  logic             clock = 1'b0;
  logic             clear = 1'b0;
  logic             det_raw = 1'b0;
  logic             count_clr = 1'b0;
  logic             x;
  logic [CNT_W-1:0] car_count;
  logic             fault;
  logic [1:0]       state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int m_s1, m_s2, m_db, m_run, m_mode, m_age, m_cnt;

  country_sensor #(
    .DEBOUNCE(DEBOUNCE), .HOLD(HOLD), .STUCK(STUCK), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .clear(clear), .det_raw(det_raw), .count_clr(count_clr),
    .x(x), .car_count(car_count), .fault(fault), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_db = 0; m_run = 0;
    m_mode = M_IDLE; m_age = 0; m_cnt = 0;
  endtask

  // One clock edge of the behavioural model; raw/cc are the values seen at the edge.
  task automatic model_edge(input int raw, input int cc);
    int n_db, n_run, n_mode, n_age, n_cnt;
    n_db = m_db; n_run = 0;
    if (m_s2 != m_db) begin
      if (m_run + 1 == DEBOUNCE) n_db = m_s2;
      else                       n_run = m_run + 1;
    end
    n_mode = m_mode; n_age = m_age + 1;
    n_cnt  = cc ? 0 : m_cnt;
    case (m_mode)
      M_IDLE: if (m_db == 1) begin
        n_mode = M_PRESENT; n_age = 0;
        n_cnt  = cc ? 1 : ((m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1);
      end
      M_PRESENT: begin
        if (m_db == 0)             begin n_mode = M_HOLD; n_age = 0; end
        else if (n_age == STUCK)   n_mode = M_FAULT;
      end
      M_HOLD: begin
        if (m_db == 1)             begin n_mode = M_PRESENT; n_age = 0; end
        else if (n_age == HOLD)    n_mode = M_IDLE;
      end
      default: if (m_db == 0) n_mode = M_IDLE;
    endcase
    m_s2 = m_s1; m_s1 = raw;
    m_db = n_db; m_run = n_run;
    m_mode = n_mode; m_age = n_age; m_cnt = n_cnt;
  endtask

  // Drive inputs on the falling edge, advance one rising edge, compare to model.
  task automatic step(input logic raw, input logic cc);
    @(negedge clock);
    det_raw   = raw;
    count_clr = cc;
    @(posedge clock);
    model_edge(int'(raw), int'(cc));
    #1;
    check_eq("x",     32'(x),         32'(m_mode != M_IDLE));
    check_eq("fault", 32'(fault),     32'(m_mode == M_FAULT));
    check_eq("count", 32'(car_count), 32'(m_cnt));
  endtask

  task automatic do_reset(input logic raw);
    @(negedge clock);
    clear = 1'b1; det_raw = raw; count_clr = 1'b0;
    #2;
    check_eq("rst_x",     32'(x),         32'd0);
    check_eq("rst_fault", 32'(fault),     32'd0);
    check_eq("rst_count", 32'(car_count), 32'd0);
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_hold_x",   32'(x),         32'd0);
    check_eq("rst_hold_cnt", 32'(car_count), 32'd0);
    @(negedge clock);
    clear = 1'b0;
    model_reset();
  endtask

  initial begin
    logic seen_x, dropped, ever_x;
    int lvl, len;
    model_reset();

    // Reset with the detector active
    do_reset(1'b1);

    // Single car: rise at edge 7, fall 15 edges after release
    do_reset(1'b0);
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1'b0);
      if (i == 6) check_eq("car_rise_e6", 32'(x), 32'd0);
      if (i == 7) begin
        check_eq("car_rise_e7", 32'(x), 32'd1);
        check_eq("car_count_e7", 32'(car_count), 32'd1);
      end
    end
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, 1'b0);
      if (i == 14) check_eq("car_fall_e14", 32'(x), 32'd1);
      if (i == 15) check_eq("car_fall_e15", 32'(x), 32'd0);
    end

    // Narrow pulse is rejected
    do_reset(1'b0);
    ever_x = 1'b0;
    for (int i = 0; i < 3; i++)  begin step(1'b1, 1'b0); ever_x |= x; end
    for (int i = 0; i < 20; i++) begin step(1'b0, 1'b0); ever_x |= x; end
    check_eq("pulse_no_x", 32'(ever_x), 32'd0);
    check_eq("pulse_count", 32'(car_count), 32'd0);

    // Short gap is bridged: one vehicle, x never drops
    do_reset(1'b0);
    seen_x = 1'b0; dropped = 1'b0;
    for (int i = 0; i < 45; i++) begin
      step((i < 20 || i >= 25) ? 1'b1 : 1'b0, 1'b0);
      if (seen_x && !x) dropped = 1'b1;
      if (x) seen_x = 1'b1;
    end
    check_eq("gap_seen_x", 32'(seen_x), 32'd1);
    check_eq("gap_no_drop", 32'(dropped), 32'd0);
    check_eq("gap_count", 32'(car_count), 32'd1);
    for (int i = 0; i < 25; i++) step(1'b0, 1'b0);

    // Stuck detector: fault at edge 262, clears 7 edges after release
    do_reset(1'b0);
    for (int i = 1; i <= 300; i++) begin
      step(1'b1, 1'b0);
      if (i == 261) check_eq("stuck_e261", 32'(fault), 32'd0);
      if (i == 262) begin
        check_eq("stuck_e262", 32'(fault), 32'd1);
        check_eq("stuck_x", 32'(x), 32'd1);
      end
    end
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 1'b0);
      if (i == 6) check_eq("unstuck_e6", 32'({x, fault}), 32'd3);
      if (i == 7) check_eq("unstuck_e7", 32'({x, fault}), 32'd0);
    end
    check_eq("stuck_count", 32'(car_count), 32'd1);

    // Counter saturation, then clear on the increment edge
    do_reset(1'b0);
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
      for (int i = 0; i < 25; i++) step(1'b0, 1'b0);
    end
    check_eq("sat_count", 32'(car_count), 32'(CNT_MAX));
    for (int i = 1; i <= 10; i++) step(1'b1, (i == 7) ? 1'b1 : 1'b0);
    check_eq("clr_inc_count", 32'(car_count), 32'd1);
    for (int i = 0; i < 25; i++) step(1'b0, 1'b0);

    // Asynchronous clear in the middle of HOLD
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 20 && m_mode != M_HOLD; i++) step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check_eq("hold_before_clr", 32'(state_dbg), 32'(M_HOLD));
    @(negedge clock);
    #1 clear = 1'b1;
    #1;
    check_eq("async_x", 32'(x), 32'd0);
    check_eq("async_fault", 32'(fault), 32'd0);
    #1 clear = 1'b0;
    model_reset();
    step(1'b0, 1'b0);
    check_eq("async_idle", 32'(state_dbg), 32'(M_IDLE));

    // Random detector activity with occasional counter clears
    for (int seg = 0; seg < 140; seg++) begin
      lvl = $urandom_range(0, 1);
      len = (seg == 70) ? 280 : (($urandom_range(0, 3) == 0) ? $urandom_range(1, 5)
                                                             : $urandom_range(1, 30));
      if (seg == 70) lvl = 1;
      for (int i = 0; i < len; i++)
        step(lvl[0], ($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
